// File: rtl/iq_unpack.sv
// Unpacks words of PAIRS_PER_WORD packed I/Q sample pairs from a FWFT FIFO into
// sign-extended, scaled I/Q samples written one pair per cycle.
module iq_unpack #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned SAMPLE_WIDTH   = 16,
    parameter int unsigned QUANTIZE_WIDTH = 10,
    parameter int unsigned PAIRS_PER_WORD = 2
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic [PAIRS_PER_WORD*2*SAMPLE_WIDTH-1:0] in_dout,
    input  logic                                     in_empty,
    output logic                                     in_rd_en,
    input  logic                                     byte_swap,
    input  logic                                     out_full,
    output logic                                     out_wr_en,
    output logic [DATA_WIDTH-1:0]                    i_dout,
    output logic [DATA_WIDTH-1:0]                    q_dout,
    output logic [31:0]                              pair_count,
    output logic                                     busy
);

    localparam int unsigned IN_WIDTH = PAIRS_PER_WORD * 2 * SAMPLE_WIDTH;
    localparam int unsigned NBYTES   = SAMPLE_WIDTH / 8;
    localparam int unsigned IDX_W    = (PAIRS_PER_WORD > 1) ? $clog2(PAIRS_PER_WORD) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAIRS_PER_WORD - 1);

    if (DATA_WIDTH < SAMPLE_WIDTH + QUANTIZE_WIDTH) begin : g_bad_data_width
        $error("iq_unpack: DATA_WIDTH must be >= SAMPLE_WIDTH + QUANTIZE_WIDTH");
    end
    if ((SAMPLE_WIDTH % 8) != 0 || SAMPLE_WIDTH == 0) begin : g_bad_sample_width
        $error("iq_unpack: SAMPLE_WIDTH must be a non-zero multiple of 8");
    end
    if (PAIRS_PER_WORD < 1 || PAIRS_PER_WORD > 8) begin : g_bad_pairs
        $error("iq_unpack: PAIRS_PER_WORD must be in 1..8");
    end

    typedef enum logic {FETCH, EMIT} state_t;

    state_t                state_q, state_d;
    logic [IN_WIDTH-1:0]   word_q, word_d;
    logic                  swap_q, swap_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [31:0]           pair_count_q, pair_count_d;
    logic                  hold_q;
    logic                  strobe_ok;

    logic [SAMPLE_WIDTH-1:0] i_raw, q_raw, i_smp, q_smp;
    logic [DATA_WIDTH-1:0]   i_ext, q_ext;

    always_comb begin
        i_raw = '0;
        q_raw = '0;
        for (int unsigned k = 0; k < PAIRS_PER_WORD; k++) begin
            if (idx_q == IDX_W'(k)) begin
                i_raw = word_q[k*2*SAMPLE_WIDTH +: SAMPLE_WIDTH];
                q_raw = word_q[k*2*SAMPLE_WIDTH + SAMPLE_WIDTH +: SAMPLE_WIDTH];
            end
        end
        i_smp = i_raw;
        q_smp = q_raw;
        if (swap_q) begin
            for (int unsigned b = 0; b < NBYTES; b++) begin
                i_smp[b*8 +: 8] = i_raw[(NBYTES-1-b)*8 +: 8];
                q_smp[b*8 +: 8] = q_raw[(NBYTES-1-b)*8 +: 8];
            end
        end
        i_ext  = DATA_WIDTH'($signed(i_smp));
        q_ext  = DATA_WIDTH'($signed(q_smp));
        i_dout = i_ext << QUANTIZE_WIDTH;
        q_dout = q_ext << QUANTIZE_WIDTH;
    end

    // Strobes are suppressed in the reset cycle and the one following it.
    assign strobe_ok = !reset && !hold_q;

    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        swap_d       = swap_q;
        idx_d        = idx_q;
        pair_count_d = pair_count_q;
        in_rd_en     = 1'b0;
        out_wr_en    = 1'b0;
        unique case (state_q)
            FETCH: begin
                if (!in_empty && strobe_ok) begin
                    in_rd_en = 1'b1;
                    word_d   = in_dout;
                    swap_d   = byte_swap;
                    idx_d    = '0;
                    state_d  = EMIT;
                end
            end
            EMIT: begin
                if (!out_full && strobe_ok) begin
                    out_wr_en    = 1'b1;
                    pair_count_d = pair_count_q + 32'd1;
                    if (idx_q != LAST_IDX) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else if (!in_empty) begin
                        in_rd_en = 1'b1;
                        word_d   = in_dout;
                        swap_d   = byte_swap;
                        idx_d    = '0;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= FETCH;
            word_q       <= '0;
            swap_q       <= 1'b0;
            idx_q        <= '0;
            pair_count_q <= '0;
            hold_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            swap_q       <= swap_d;
            idx_q        <= idx_d;
            pair_count_q <= pair_count_d;
            hold_q       <= 1'b0;
        end
    end

    assign pair_count = pair_count_q;
    assign busy       = (state_q == EMIT);

endmodule

// File: tb/tb_iq_unpack.sv
// Directed bench for iq_unpack: one 1-pair instance and one 2-pair instance fed
// from queue-modelled FWFT FIFOs, with a scoreboard of hand-computed pairs.
module tb_iq_unpack;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [31:0] in_dout1;
    logic        in_empty1, rd1, bs1, full1, wr1, busy1;
    logic [31:0] i1, q1, pc1;

    logic [63:0] in_dout2;
    logic        in_empty2, rd2, bs2, full2, wr2, busy2;
    logic [31:0] i2, q2, pc2;

    iq_unpack #(.DATA_WIDTH(32), .SAMPLE_WIDTH(16), .QUANTIZE_WIDTH(10), .PAIRS_PER_WORD(1)) dut1 (
        .clock(clk), .reset(reset), .in_dout(in_dout1), .in_empty(in_empty1), .in_rd_en(rd1),
        .byte_swap(bs1), .out_full(full1), .out_wr_en(wr1), .i_dout(i1), .q_dout(q1),
        .pair_count(pc1), .busy(busy1)
    );

    iq_unpack #(.DATA_WIDTH(32), .SAMPLE_WIDTH(16), .QUANTIZE_WIDTH(10), .PAIRS_PER_WORD(2)) dut2 (
        .clock(clk), .reset(reset), .in_dout(in_dout2), .in_empty(in_empty2), .in_rd_en(rd2),
        .byte_swap(bs2), .out_full(full2), .out_wr_en(wr2), .i_dout(i2), .q_dout(q2),
        .pair_count(pc2), .busy(busy2)
    );

    logic [31:0] fifo1[$];
    logic [63:0] fifo2[$];
    logic [63:0] exp1[$];
    logic [63:0] exp2[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic        s_rd1, s_wr1, s_busy1, s_rd2, s_wr2, s_busy2;
    logic [31:0] s_i1, s_q1, s_pc1, s_i2, s_q2, s_pc2;
    int last_rd1 = 0, last_wr1 = 0;
    int first_wr2 = -1, last_wr2 = 0, n_wr2 = 0;
    int rd2_cyc[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expv);
        end
    endtask

    // One clock cycle: present FIFO heads, sample outputs before the rising edge,
    // score writes, then pop whatever the DUTs read.
    task automatic step();
        in_empty1 = (fifo1.size() == 0);
        in_dout1  = in_empty1 ? 32'h0 : fifo1[0];
        in_empty2 = (fifo2.size() == 0);
        in_dout2  = in_empty2 ? 64'h0 : fifo2[0];
        #1;
        s_rd1 = rd1; s_wr1 = wr1; s_i1 = i1; s_q1 = q1; s_pc1 = pc1; s_busy1 = busy1;
        s_rd2 = rd2; s_wr2 = wr2; s_i2 = i2; s_q2 = q2; s_pc2 = pc2; s_busy2 = busy2;
        cyc++;
        check("rd1_when_empty", 64'(s_rd1 & in_empty1), 64'h0);
        check("rd2_when_empty", 64'(s_rd2 & in_empty2), 64'h0);
        if (s_wr1) begin
            last_wr1 = cyc;
            if (exp1.size() == 0) check("wr1_unexpected", 64'h1, 64'h0);
            else begin
                check("pair1", {s_q1, s_i1}, exp1[0]);
                void'(exp1.pop_front());
            end
        end
        if (s_wr2) begin
            if (first_wr2 < 0) first_wr2 = cyc;
            last_wr2 = cyc;
            n_wr2++;
            if (exp2.size() == 0) check("wr2_unexpected", 64'h1, 64'h0);
            else begin
                check("pair2", {s_q2, s_i2}, exp2[0]);
                void'(exp2.pop_front());
            end
        end
        if (s_rd1) last_rd1 = cyc;
        if (s_rd2) rd2_cyc.push_back(cyc);
        @(negedge clk);
        if (s_rd1 && fifo1.size() > 0) void'(fifo1.pop_front());
        if (s_rd2 && fifo2.size() > 0) void'(fifo2.pop_front());
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((fifo1.size() + fifo2.size() + exp1.size() + exp2.size()) != 0 && n < budget) begin
            step();
            n++;
        end
        check("drain_pending", 64'(fifo1.size() + fifo2.size() + exp1.size() + exp2.size()), 64'h0);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        bs1 = 1'b0; bs2 = 1'b0; full1 = 1'b0; full2 = 1'b0;
        in_empty1 = 1'b1; in_empty2 = 1'b1; in_dout1 = '0; in_dout2 = '0;
        @(negedge clk);
        repeat (3) step();
        check("rst_pc1", 64'(s_pc1), 64'h0);
        check("rst_pc2", 64'(s_pc2), 64'h0);
        check("rst_i1q1", {s_q1, s_i1}, 64'h0);
        check("rst_i2q2", {s_q2, s_i2}, 64'h0);
        check("rst_busy", {62'h0, s_busy1, s_busy2}, 64'h0);
        check("rst_strobes", {60'h0, s_rd1, s_wr1, s_rd2, s_wr2}, 64'h0);
        reset = 1'b0;
        repeat (2) step();

        // 1-pair word, no swap
        fifo1.push_back(32'h00C0FF80);
        exp1.push_back({32'h00030000, 32'hFFFE0000});
        drain(20);
        check("latency_noswap", 64'(last_wr1 - last_rd1), 64'h1);
        #1;
        check("fetch_after_word", 64'(busy1), 64'h0);

        // Same word, byte swap
        bs1 = 1'b1;
        fifo1.push_back(32'h00C0FF80);
        exp1.push_back({32'hFF000000, 32'hFE03FC00});
        drain(20);
        check("latency_swap", 64'(last_wr1 - last_rd1), 64'h1);
        check("pc1_two", 64'(pc1), 64'h2);
        bs1 = 1'b0;

        // Three 2-pair words back to back
        first_wr2 = -1; n_wr2 = 0; rd2_cyc.delete();
        fifo2.push_back(64'h0004_0003_0002_0001);
        fifo2.push_back(64'hFFFF_FFFE_0010_7FFF);
        fifo2.push_back(64'h8000_0000_1234_8000);
        exp2.push_back({32'h00000800, 32'h00000400});
        exp2.push_back({32'h00001000, 32'h00000C00});
        exp2.push_back({32'h00004000, 32'h01FFFC00});
        exp2.push_back({32'hFFFFFC00, 32'hFFFFF800});
        exp2.push_back({32'h0048D000, 32'hFE000000});
        exp2.push_back({32'hFE000000, 32'h00000000});
        drain(40);
        check("burst_writes", 64'(n_wr2), 64'h6);
        check("burst_span", 64'(last_wr2 - first_wr2), 64'h5);
        check("burst_pops", 64'(rd2_cyc.size()), 64'h3);
        if (rd2_cyc.size() == 3) begin
            check("first_latency", 64'(first_wr2 - rd2_cyc[0]), 64'h1);
            check("pop_gap_a", 64'(rd2_cyc[1] - rd2_cyc[0]), 64'h2);
            check("pop_gap_b", 64'(rd2_cyc[2] - rd2_cyc[1]), 64'h2);
        end
        check("pc2_six", 64'(pc2), 64'h6);

        // Backpressure mid-word; swap latched at pop, changed afterwards
        bs2 = 1'b1;
        fifo2.push_back(64'h0008_0007_0006_0005);
        exp2.push_back({32'h00180000, 32'h00140000});
        exp2.push_back({32'h00200000, 32'h001C0000});
        n = 0;
        do begin step(); n++; end while (!s_rd2 && n < 10);
        check("bp_pop", 64'(s_rd2), 64'h1);
        bs2 = 1'b0;
        step();
        check("bp_first_wr", 64'(s_wr2), 64'h1);
        full2 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("full_no_wr", 64'(s_wr2), 64'h0);
            check("full_no_rd", 64'(s_rd2), 64'h0);
            check("full_hold", {s_q2, s_i2}, {32'h00200000, 32'h001C0000});
            check("full_busy", 64'(s_busy2), 64'h1);
        end
        full2 = 1'b0;
        step();
        check("resume_wr", 64'(s_wr2), 64'h1);
        check("no_loss", 64'(exp2.size()), 64'h0);
        check("pc2_eight", 64'(pc2), 64'h8);

        // Reset after first pair of a word discards the second pair
        fifo2.push_back(64'h1111_2222_3333_4444);
        exp2.push_back({32'h00CCCC00, 32'h01111000});
        n = 0;
        do begin step(); n++; end while (!s_wr2 && n < 10);
        check("pre_rst_wr", 64'(s_wr2), 64'h1);
        fifo2.push_back(64'h0000_0001_0000_FFFF);
        exp2.push_back({32'h00000000, 32'hFFFFFC00});
        exp2.push_back({32'h00000000, 32'h00000400});
        reset = 1'b1;
        step();
        check("rst_cycle_strobes", {62'h0, s_wr2, s_rd2}, 64'h0);
        reset = 1'b0;
        step();
        check("post_rst_strobes", {62'h0, s_wr2, s_rd2}, 64'h0);
        check("post_rst_pc2", 64'(s_pc2), 64'h0);
        check("post_rst_busy2", 64'(s_busy2), 64'h0);
        drain(20);
        check("pc2_after_rst", 64'(pc2), 64'h2);

        // pair_count wrap
        force dut1.pair_count_q = 32'hFFFF_FFFF;
        #1;
        release dut1.pair_count_q;
        check("pc1_preset", 64'(pc1), 64'hFFFF_FFFF);
        fifo1.push_back(32'h0001_0002);
        exp1.push_back({32'h00000400, 32'h00000800});
        drain(20);
        check("pc1_wrap", 64'(pc1), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iq_unpack.md
IQ_UNPACK -- requirements
Module: iq_unpack

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of each output I/Q sample.
REQ-002 Parameter SAMPLE_WIDTH, default 16: width of one packed I or Q sample; must be a multiple of 8.
REQ-003 Parameter QUANTIZE_WIDTH, default 10: left-shift (×2^QUANTIZE_WIDTH) applied to every sample.
REQ-004 Parameter PAIRS_PER_WORD, default 2: number of I/Q pairs packed in one input word; range 1..8.
REQ-005 Localparam IN_WIDTH = PAIRS_PER_WORD*2*SAMPLE_WIDTH.
REQ-006 clock  in  1  single clock; all state updates on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 in_dout  in  IN_WIDTH  head word of upstream first-word-fall-through FIFO, valid while in_empty=0.
REQ-009 in_empty  in  1  upstream FIFO empty.
REQ-010 in_rd_en  out  1  pop strobe to upstream FIFO.
REQ-011 byte_swap  in  1  mode: 1 = reverse byte order inside each sample; sampled only when a word is popped.
REQ-012 out_full  in  1  downstream I/Q FIFO pair full.
REQ-013 out_wr_en  out  1  write strobe; i_dout/q_dout valid in the same cycle.
REQ-014 i_dout  out  DATA_WIDTH  scaled I sample.
REQ-015 q_dout  out  DATA_WIDTH  scaled Q sample.
REQ-016 pair_count  out  32  number of pairs written since reset; wraps 0xFFFFFFFF->0.
REQ-017 busy  out  1  high while a popped word still holds unwritten pairs.

Function
REQ-018 Pair k (0..PAIRS_PER_WORD-1) occupies in_dout[k*2*SAMPLE_WIDTH +: 2*SAMPLE_WIDTH]; I is the lower SAMPLE_WIDTH bits, Q the upper.
REQ-019 Pairs are emitted in ascending k order, one pair per out_wr_en.
REQ-020 Arithmetic: sample sign-extended to DATA_WIDTH, shifted left by QUANTIZE_WIDTH, truncated to DATA_WIDTH; elaboration fails if DATA_WIDTH < SAMPLE_WIDTH+QUANTIZE_WIDTH.
REQ-021 byte_swap=1: each sample's bytes are reversed before sign-extension; the byte_swap value captured at pop applies to all pairs of that word.
REQ-022 FSM states: FETCH and EMIT; reset state FETCH.
REQ-023 FETCH: in_rd_en = !in_empty; on pop, the word and byte_swap are latched, index <= 0, next state EMIT; otherwise stay.
REQ-024 EMIT: out_wr_en = !out_full; when out_full=1, hold index and data and assert no strobes.
REQ-025 EMIT write with index < PAIRS_PER_WORD-1: index increments, stay EMIT.
REQ-026 EMIT write of last pair with in_empty=0: in_rd_en=1 in the same cycle, next word latched, index <= 0, stay EMIT (back-to-back, no bubble).
REQ-027 EMIT write of last pair with in_empty=1: next state FETCH.
REQ-028 in_rd_en is never asserted when in_empty=1 and never in EMIT except per REQ-026.
REQ-029 Latency: word present in FETCH at cycle t -> first out_wr_en at t+1 if out_full=0; sustained throughput one pair per cycle.
REQ-030 i_dout/q_dout are don't-care when out_wr_en=0 but shall not be X after reset.
REQ-031 pair_count increments by exactly 1 per out_wr_en.
REQ-032 busy = (state == EMIT).

Reset
REQ-033 On reset: state FETCH, index 0, latched word 0, pair_count 0; in_rd_en, out_wr_en, busy 0; i_dout, q_dout 0.
REQ-034 Reset mid-word discards unwritten pairs; no strobe is asserted in the reset cycle or the cycle after it.

Verification
REQ-035 PAIRS_PER_WORD=1, in_dout=0x00C0FF80, byte_swap=0 -> one write with i_dout=0xFFFE0000 and q_dout=0x00030000; then FETCH.
REQ-036 Same word with byte_swap=1 -> I=0x80FF (-32513) gives i_dout=0xFE03FC00; Q=0xC000 (-16384) gives q_dout=0xFF000000.
REQ-037 PAIRS_PER_WORD=2, three words queued, out_full=0 -> six consecutive writes, in_rd_en pulses every second cycle, pair_count=6, no idle cycles.
REQ-038 out_full asserted for 3 cycles mid-word -> no writes, outputs held, writes resume with the same pair; no pair lost or duplicated.
REQ-039 Extremes 0x7FFF/0x8000 -> 0x01FFFC00/0xFE000000; reset asserted after first pair of a 2-pair word -> remaining pair is never written and pair_count=0.
REQ-040 pair_count preset via force to 0xFFFFFFFF, one write -> wraps to 0.
